// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory port: data width, load/store func3 codes,
// and the access-size encoding also used by the core's LSU.
package dmem_responder_pkg;

  localparam int unsigned dw = 64;

  // STORE_FUNC3
  localparam logic [2:0] SB = 3'd0;
  localparam logic [2:0] SH = 3'd1;
  localparam logic [2:0] SW = 3'd2;
  localparam logic [2:0] SD = 3'd3;

  // LOAD_FUNC3
  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LD  = 3'd3;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  localparam logic [2:0] LWU = 3'd6;

  typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W, MEM_D} mem_size_t;

  function automatic logic [7:0] size_mask(input mem_size_t size);
    case (size)
      MEM_B:   return 8'h01;
      MEM_H:   return 8'h03;
      MEM_W:   return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for one 64-bit word: store mask/data placement, load extraction
// with sign/zero extension, and natural-alignment check.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [2:0]    func3,
  input  logic [2:0]    off,
  input  logic [dw-1:0] wdata,
  input  logic [dw-1:0] word,
  output logic [7:0]    byte_en,
  output logic [dw-1:0] wdata_lane,
  output logic [dw-1:0] rdata,
  output logic          misalign
);

  mem_size_t     size;
  logic [5:0]    bit_off;
  logic [dw-1:0] shifted;

  always_comb begin
    size       = mem_size_t'(func3[1:0]);
    bit_off    = {off, 3'b000};
    byte_en    = size_mask(size) << off;
    wdata_lane = wdata << bit_off;
    shifted    = word >> bit_off;

    case (size)
      MEM_B:   misalign = 1'b0;
      MEM_H:   misalign = off[0];
      MEM_W:   misalign = |off[1:0];
      default: misalign = |off;
    endcase

    case (func3)
      LB:      rdata = {{56{shifted[7]}},  shifted[7:0]};
      LH:      rdata = {{48{shifted[15]}}, shifted[15:0]};
      LW:      rdata = {{32{shifted[31]}}, shifted[31:0]};
      LD:      rdata = shifted;
      LBU:     rdata = {56'd0, shifted[7:0]};
      LHU:     rdata = {48'd0, shifted[15:0]};
      LWU:     rdata = {32'd0, shifted[31:0]};
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the RV64I load/store port: one request at a time,
// fixed LATENCY from accept to response, byte-lane writes into a DEPTH_DW x 64b array.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_DW = 1024,
  parameter int unsigned LATENCY  = 2
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_func3,
  input  logic [dw-1:0] req_addr,
  input  logic [dw-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [dw-1:0] rsp_rdata,
  output logic          rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_DW);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_next;
  logic [3:0]    cnt;
  logic          we_q;
  logic [2:0]    func3_q;
  logic [dw-1:0] addr_q, wdata_q;

  logic          accept, access;
  logic          op_we;
  logic [2:0]    op_func3;
  logic [dw-1:0] op_addr, op_wdata;
  logic [AW-1:0] idx;
  logic [7:0]    byte_en;
  logic [dw-1:0] wdata_lane, load_data;
  logic          misalign, out_of_range, illegal, err;

  logic [dw-1:0] mem [DEPTH_DW];

  assign accept = req_valid && req_ready;

  // With LATENCY=1 the accept edge is also the access edge, so the live request is used.
  assign op_we    = (state == IDLE) ? req_we    : we_q;
  assign op_func3 = (state == IDLE) ? req_func3 : func3_q;
  assign op_addr  = (state == IDLE) ? req_addr  : addr_q;
  assign op_wdata = (state == IDLE) ? req_wdata : wdata_q;
  assign access   = (state == IDLE) ? (accept && LATENCY == 1)
                                    : (state == WAIT && cnt == 4'd1);

  assign idx          = op_addr[AW+2:3];
  assign out_of_range = op_addr[dw-1:3] >= (dw-3)'(DEPTH_DW);
  assign illegal      = op_we ? op_func3[2] : (op_func3 == 3'b111);
  assign err          = misalign || out_of_range || illegal;

  dmem_lane_align u_align (
    .func3      (op_func3),
    .off        (op_addr[2:0]),
    .wdata      (op_wdata),
    .word       (mem[idx]),
    .byte_en    (byte_en),
    .wdata_lane (wdata_lane),
    .rdata      (load_data),
    .misalign   (misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (cnt == 4'd1) state_next = RESP;
      RESP: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      we_q      <= 1'b0;
      func3_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        func3_q <= req_func3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt     <= 4'(LATENCY - 1);
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        rsp_err   <= err;
        rsp_rdata <= (err || op_we) ? '0 : load_data;
      end else if (state == RESP && rsp_ready) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= '0;
      end
    end
  end

  // rst_n gate keeps a request presented during reset from writing.
  always_ff @(posedge clk) begin
    if (access && rst_n && op_we && !err) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (byte_en[i]) mem[idx][8*i +: 8] <= wdata_lane[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance for function, errors,
// backpressure and reset abort; LATENCY=1 instance for single-edge latency.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_func3 = '0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        valid0 = 1'b0, valid1 = 1'b0, rr0 = 1'b0, rr1 = 1'b0;
  logic        ready0, ready1, rv0, rv1, err0, err1;
  logic [63:0] rd0, rd1;

  int          sel = 0;
  logic        cur_ready, cur_rv, cur_err;
  logic [63:0] cur_rd;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_DW(1024), .LATENCY(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid0), .req_ready(ready0),
    .req_we(req_we), .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv0), .rsp_ready(rr0), .rsp_rdata(rd0), .rsp_err(err0)
  );

  dmem_responder #(.DEPTH_DW(1024), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid1), .req_ready(ready1),
    .req_we(req_we), .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_ready(rr1), .rsp_rdata(rd1), .rsp_err(err1)
  );

  always_comb begin
    cur_ready = (sel == 0) ? ready0 : ready1;
    cur_rv    = (sel == 0) ? rv0    : rv1;
    cur_err   = (sel == 0) ? err0   : err1;
    cur_rd    = (sel == 0) ? rd0    : rd1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                     input logic [63:0] a, input logic [63:0] wd,
                     input logic [63:0] exp_rd, input logic exp_err,
                     input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    check({tag, "/req_ready"}, 64'(cur_ready), 64'd1);
    req_we = we; req_func3 = f3; req_addr = a; req_wdata = wd;
    if (sel == 0) valid0 = 1'b1; else valid1 = 1'b1;
    @(posedge clk); #1;
    valid0 = 1'b0; valid1 = 1'b0;
    lat = 1;
    while (!cur_rv && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "/rdata"}, cur_rd, exp_rd);
    check({tag, "/err"}, 64'(cur_err), 64'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check($sformatf("%s/hold%0d_valid", tag, i), 64'(cur_rv), 64'd1);
      check($sformatf("%s/hold%0d_rdata", tag, i), cur_rd, exp_rd);
      check($sformatf("%s/hold%0d_ready", tag, i), 64'(cur_ready), 64'd0);
    end
    if (sel == 0) rr0 = 1'b1; else rr1 = 1'b1;
    @(posedge clk); #1;
    rr0 = 1'b0; rr1 = 1'b0;
    check({tag, "/done_valid"}, 64'(cur_rv), 64'd0);
    check({tag, "/done_ready"}, 64'(cur_ready), 64'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset/rsp_valid", 64'(rv0), 64'd0);
    check("reset/rsp_rdata", rd0, 64'd0);
    check("reset/rsp_err", 64'(err0), 64'd0);
    check("reset/req_ready", 64'(ready0), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    sel = 0;
    txn("sd10",   1'b1, SD,  64'h10, 64'h1122334455667788, 64'h0, 1'b0, 2, 0);
    txn("ld10a",  1'b0, LD,  64'h10, 64'h0, 64'h1122334455667788, 1'b0, 2, 0);
    txn("sb13",   1'b1, SB,  64'h13, 64'hFF, 64'h0, 1'b0, 2, 0);
    txn("lb13",   1'b0, LB,  64'h13, 64'h0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 2, 0);
    txn("lbu13",  1'b0, LBU, 64'h13, 64'h0, 64'h00000000000000FF, 1'b0, 2, 0);
    txn("ld10b",  1'b0, LD,  64'h10, 64'h0, 64'h11223344FF667788, 1'b0, 2, 0);
    txn("sw14",   1'b1, SW,  64'h14, 64'h80000000, 64'h0, 1'b0, 2, 0);
    txn("lw14",   1'b0, LW,  64'h14, 64'h0, 64'hFFFFFFFF80000000, 1'b0, 2, 0);
    txn("lwu14",  1'b0, LWU, 64'h14, 64'h0, 64'h0000000080000000, 1'b0, 2, 0);
    txn("lhu16",  1'b0, LHU, 64'h16, 64'h0, 64'h0000000000008000, 1'b0, 2, 0);

    txn("err_lw12",  1'b0, LW,   64'h12, 64'h0, 64'h0, 1'b1, 2, 0);
    txn("err_sh11",  1'b1, SH,   64'h11, 64'hABCD, 64'h0, 1'b1, 2, 0);
    txn("ld10c",     1'b0, LD,   64'h10, 64'h0, 64'h80000000FF667788, 1'b0, 2, 0);
    txn("err_oor",   1'b0, LD,   64'h2000, 64'h0, 64'h0, 1'b1, 2, 0);
    txn("ld_top",    1'b0, LD,   64'h1FF8, 64'h0, 64'h0, 1'b0, 2, 0);
    txn("err_f3_7",  1'b0, 3'd7, 64'h10, 64'h0, 64'h0, 1'b1, 2, 0);
    txn("err_st_f4", 1'b1, 3'd4, 64'h10, 64'hDEAD, 64'h0, 1'b1, 2, 0);
    txn("ld10d",     1'b0, LD,   64'h10, 64'h0, 64'h80000000FF667788, 1'b0, 2, 0);

    txn("bp_ld10", 1'b0, LD, 64'h10, 64'h0, 64'h80000000FF667788, 1'b0, 2, 5);

    txn("sd20", 1'b1, SD, 64'h20, 64'hCAFEF00D12345678, 64'h0, 1'b0, 2, 0);
    @(negedge clk);
    req_we = 1'b1; req_func3 = SD; req_addr = 64'h20; req_wdata = 64'hDEADBEEFDEADBEEF;
    valid0 = 1'b1;
    @(posedge clk); #1;
    valid0 = 1'b0;
    check("abort/wait_ready", 64'(ready0), 64'd0);
    rst_n = 1'b0;
    #1;
    check("abort/rsp_valid", 64'(rv0), 64'd0);
    check("abort/rsp_rdata", rd0, 64'd0);
    check("abort/rsp_err", 64'(err0), 64'd0);
    @(posedge clk); #1;
    check("abort/still_idle_valid", 64'(rv0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    txn("ld20", 1'b0, LD, 64'h20, 64'h0, 64'hCAFEF00D12345678, 1'b0, 2, 0);

    sel = 1;
    txn("l1_sd08",  1'b1, SD, 64'h08, 64'h0123456789ABCDEF, 64'h0, 1'b0, 1, 0);
    txn("l1_ld08",  1'b0, LD, 64'h08, 64'h0, 64'h0123456789ABCDEF, 1'b0, 1, 0);
    txn("l1_lh0a",  1'b0, LH, 64'h0A, 64'h0, 64'hFFFFFFFFFFFF89AB, 1'b0, 1, 0);
    txn("l1_err09", 1'b0, LD, 64'h09, 64'h0, 64'h0, 1'b1, 1, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
